// File: rtl/alu_exec_stage_pkg.sv
// Shared types and constants for the ALU execute stage and its shift/ALU datapath.
// Widths are fixed here for the 8x16 register file.
package alu_exec_stage_pkg;

  localparam int unsigned K = 16;  // datapath width
  localparam int unsigned N = 3;   // register-number width

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoadA = 3'd1,
    StLoadB = 3'd2,
    StExec  = 3'd3,
    StWrite = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    OpAdd = 2'b00,
    OpSub = 2'b01,
    OpAnd = 2'b10,
    OpMvn = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ShNone = 2'b00,
    ShLsl1 = 2'b01,
    ShLsr1 = 2'b10,
    ShAsr1 = 2'b11
  } shift_e;

  // Bit positions within the {Z,N,V} status word
  localparam int unsigned StatZ = 2;
  localparam int unsigned StatN = 1;
  localparam int unsigned StatV = 0;

  function automatic logic [K-1:0] apply_shift(input logic [K-1:0] b, input shift_e sh);
    logic [K-1:0] res;
    unique case (sh)
      ShNone:  res = b;
      ShLsl1:  res = {b[K-2:0], 1'b0};
      ShLsr1:  res = {1'b0, b[K-1:1]};
      ShAsr1:  res = {b[K-1], b[K-1:1]};
      default: res = b;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_exec_stage_if.sv
// Controller / register-file bundle seen by the execute stage.
// The slave modport is the stage itself; master is the controller plus register file.
interface alu_exec_stage_if;
  import alu_exec_stage_pkg::*;

  logic         start;
  logic [N-1:0] rn;
  logic [N-1:0] rm;
  logic [N-1:0] rd;
  logic [1:0]   alu_op;
  logic [1:0]   shift;
  logic [K-1:0] data_in;
  logic [N-1:0] readnum;
  logic [N-1:0] writenum;
  logic         write;
  logic [K-1:0] wb_data;
  logic [2:0]   status;
  logic         busy;
  logic         done;

  modport master (
    output start, rn, rm, rd, alu_op, shift, data_in,
    input  readnum, writenum, write, wb_data, status, busy, done
  );

  modport slave (
    input  start, rn, rm, rd, alu_op, shift, data_in,
    output readnum, writenum, write, wb_data, status, busy, done
  );

endinterface

// File: rtl/shift_alu.sv
// Combinational shifter + ALU: shifts B, then computes ADD/SUB/AND/MVN with Z/N/V flags.
// Reusable by the full CPU datapath.
module shift_alu
  import alu_exec_stage_pkg::*;
(
  input  logic [K-1:0] a_i,
  input  logic [K-1:0] b_i,
  input  alu_op_e      op_i,
  input  shift_e       sh_i,
  output logic [K-1:0] result_o,
  output logic         z_o,
  output logic         n_o,
  output logic         v_o
);

  logic [K-1:0] bs;

  always_comb begin
    bs       = apply_shift(b_i, sh_i);
    result_o = '0;
    v_o      = 1'b0;
    unique case (op_i)
      OpAdd: begin
        result_o = a_i + bs;
        v_o      = (a_i[K-1] == bs[K-1]) && (result_o[K-1] != a_i[K-1]);
      end
      OpSub: begin
        result_o = a_i - bs;
        v_o      = (a_i[K-1] != bs[K-1]) && (result_o[K-1] != a_i[K-1]);
      end
      OpAnd:   result_o = a_i & bs;
      OpMvn:   result_o = ~bs;
      default: result_o = '0;
    endcase
    z_o = (result_o == '0);
    n_o = result_o[K-1];
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: reads Rn then Rm, runs shift_alu, and writes C back to Rd.
// One operation every five cycles: LOAD_A, LOAD_B, EXEC, WRITE, then IDLE.
module alu_exec_stage
  import alu_exec_stage_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  alu_exec_stage_if.slave  exec_io
);

  state_e       state_q, state_d;
  logic [N-1:0] rn_q, rm_q, rd_q;
  alu_op_e      op_q;
  shift_e       sh_q;
  logic [K-1:0] a_q, b_q, c_q;
  logic [2:0]   status_q;

  logic [K-1:0] alu_res;
  logic         alu_z, alu_n, alu_v;

  shift_alu u_shift_alu (
    .a_i      (a_q),
    .b_i      (b_q),
    .op_i     (op_q),
    .sh_i     (sh_q),
    .result_o (alu_res),
    .z_o      (alu_z),
    .n_o      (alu_n),
    .v_o      (alu_v)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (exec_io.start) state_d = StLoadA;
      StLoadA: state_d = StLoadB;
      StLoadB: state_d = StExec;
      StExec:  state_d = StWrite;
      StWrite: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Field capture only happens in IDLE, so a start while busy cannot disturb them
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rn_q     <= '0;
      rm_q     <= '0;
      rd_q     <= '0;
      op_q     <= OpAdd;
      sh_q     <= ShNone;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      status_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (exec_io.start) begin
            rn_q <= exec_io.rn;
            rm_q <= exec_io.rm;
            rd_q <= exec_io.rd;
            op_q <= alu_op_e'(exec_io.alu_op);
            sh_q <= shift_e'(exec_io.shift);
          end
        end
        StLoadA: a_q <= exec_io.data_in;
        StLoadB: b_q <= exec_io.data_in;
        StExec: begin
          c_q             <= alu_res;
          status_q[StatZ] <= alu_z;
          status_q[StatN] <= alu_n;
          status_q[StatV] <= alu_v;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    exec_io.readnum = '0;
    unique case (state_q)
      StLoadA: exec_io.readnum = rn_q;
      StLoadB: exec_io.readnum = rm_q;
      default: exec_io.readnum = '0;
    endcase
    // Gate with reset so an asserted reset never lets a write through
    exec_io.write    = (state_q == StWrite) & reset_n;
    exec_io.done     = (state_q == StWrite);
    exec_io.busy     = (state_q != StIdle);
    exec_io.writenum = rd_q;
    exec_io.wb_data  = c_q;
    exec_io.status   = status_q;
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: register-file model, directed operations, and a scoreboard
// monitor that checks every write-back against queued expectations.
module tb_alu_exec_stage;
  import alu_exec_stage_pkg::*;

  typedef struct packed {
    logic [2:0]  wn;
    logic [15:0] data;
    logic [2:0]  st;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  alu_exec_stage_if bus_if ();

  alu_exec_stage dut (
    .clk     (clk),
    .reset_n (reset_n),
    .exec_io (bus_if)
  );

  logic [15:0] regs [8];
  logic        ld_en = 1'b0;
  logic [2:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   write_cnt = 0;
  bit   mon_en = 1'b0;

  assign bus_if.data_in = regs[bus_if.readnum];

  always @(posedge clk) begin
    if (ld_en) regs[ld_addr] <= ld_data;
    else if (bus_if.write) regs[bus_if.writenum] <= bus_if.wb_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus_if.write) begin
        write_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("wb_writenum", {29'd0, bus_if.writenum}, {29'd0, mon_e.wn});
          check("wb_data", {16'd0, bus_if.wb_data}, {16'd0, mon_e.data});
          check("wb_status", {29'd0, bus_if.status}, {29'd0, mon_e.st});
          check("wb_done", {31'd0, bus_if.done}, 32'd1);
        end
      end else if (bus_if.done && reset_n) begin
        check("done_without_write", 32'd1, 32'd0);
      end
    end
  end

  task automatic set_reg(input logic [2:0] a, input logic [15:0] d);
    ld_addr = a;
    ld_data = d;
    ld_en   = 1'b1;
    @(posedge clk);
    #1;
    ld_en = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] rn, input logic [2:0] rm, input logic [2:0] rd,
                        input logic [1:0] op, input logic [1:0] sh,
                        input logic [15:0] exp_data, input logic [2:0] exp_st,
                        input bit poke);
    exp_q.push_back(exp_t'{wn: rd, data: exp_data, st: exp_st});
    bus_if.rn     = rn;
    bus_if.rm     = rm;
    bus_if.rd     = rd;
    bus_if.alu_op = op;
    bus_if.shift  = sh;
    bus_if.start  = 1'b1;
    @(posedge clk);
    #1;
    bus_if.start = poke;
    if (poke) begin
      bus_if.rn     = ~rn;
      bus_if.rm     = ~rm;
      bus_if.rd     = ~rd;
      bus_if.alu_op = ~op;
      bus_if.shift  = ~sh;
    end
    @(negedge clk);
    check("readnum_load_a", {29'd0, bus_if.readnum}, {29'd0, rn});
    check("busy_load_a", {31'd0, bus_if.busy}, 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("readnum_load_b", {29'd0, bus_if.readnum}, {29'd0, rm});
    @(posedge clk);
    #1;
    @(negedge clk);
    check("readnum_exec", {29'd0, bus_if.readnum}, 32'd0);
    check("write_exec", {31'd0, bus_if.write}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("done_cycle4", {31'd0, bus_if.done}, 32'd1);
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    @(negedge clk);
    check("idle_cycle5", {31'd0, bus_if.busy}, 32'd0);
  endtask

  int wc0;

  initial begin
    reset_n       = 1'b0;
    bus_if.start  = 1'b1;
    bus_if.rn     = 3'd7;
    bus_if.rm     = 3'd7;
    bus_if.rd     = 3'd7;
    bus_if.alu_op = 2'b11;
    bus_if.shift  = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, bus_if.busy}, 32'd0);
    check("rst_write", {31'd0, bus_if.write}, 32'd0);
    check("rst_done", {31'd0, bus_if.done}, 32'd0);
    check("rst_readnum", {29'd0, bus_if.readnum}, 32'd0);
    check("rst_writenum", {29'd0, bus_if.writenum}, 32'd0);
    check("rst_status", {29'd0, bus_if.status}, 32'd0);
    check("rst_wb_data", {16'd0, bus_if.wb_data}, 32'd0);
    reset_n      = 1'b1;
    bus_if.start = 1'b0;
    mon_en       = 1'b1;

    set_reg(3'd1, 16'h0005);
    set_reg(3'd2, 16'h0003);
    run_op(3'd1, 3'd2, 3'd3, 2'b00, 2'b00, 16'h0008, 3'b000, 1'b0);
    check("r3_after_add", {16'd0, regs[3]}, 32'h0008);

    // Immediately reads the register just written
    run_op(3'd3, 3'd3, 3'd1, 2'b00, 2'b00, 16'h0010, 3'b000, 1'b0);

    set_reg(3'd4, 16'h0004);
    set_reg(3'd5, 16'h0002);
    run_op(3'd4, 3'd5, 3'd4, 2'b01, 2'b01, 16'h0000, 3'b100, 1'b0);
    check("r4_after_sub", {16'd0, regs[4]}, 32'h0000);

    set_reg(3'd0, 16'h7FFF);
    set_reg(3'd1, 16'h0001);
    run_op(3'd0, 3'd1, 3'd2, 2'b00, 2'b00, 16'h8000, 3'b011, 1'b0);
    set_reg(3'd0, 16'h8000);
    run_op(3'd0, 3'd1, 3'd2, 2'b01, 2'b00, 16'h7FFF, 3'b001, 1'b0);

    set_reg(3'd6, 16'h8000);
    wc0 = write_cnt;
    run_op(3'd0, 3'd6, 3'd7, 2'b11, 2'b11, 16'h3FFF, 3'b000, 1'b1);
    check("busy_start_one_write", write_cnt - wc0, 32'd1);
    run_op(3'd0, 3'd6, 3'd5, 2'b11, 2'b10, 16'hBFFF, 3'b010, 1'b0);

    // Reset dropped during EXEC abandons the operation
    wc0 = write_cnt;
    bus_if.rn     = 3'd1;
    bus_if.rm     = 3'd2;
    bus_if.rd     = 3'd0;
    bus_if.alu_op = 2'b00;
    bus_if.shift  = 2'b00;
    bus_if.start  = 1'b1;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset_n = 1'b0;
    @(negedge clk);
    check("rstmid_write_exec", {31'd0, bus_if.write}, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("rstmid_busy", {31'd0, bus_if.busy}, 32'd0);
    check("rstmid_wb_data", {16'd0, bus_if.wb_data}, 32'd0);
    check("rstmid_status", {29'd0, bus_if.status}, 32'd0);
    check("rstmid_done", {31'd0, bus_if.done}, 32'd0);
    repeat (4) @(negedge clk);
    check("rstmid_no_write", write_cnt - wc0, 32'd0);

    set_reg(3'd1, 16'h00F0);
    set_reg(3'd2, 16'h0F3C);
    run_op(3'd1, 3'd2, 3'd3, 2'b10, 2'b00, 16'h0030, 3'b000, 1'b0);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Downstream execute stage for the 8x16 register file.
- Sequences two register-file reads (Rn, then Rm), latches them as operands A and B, and shifts B.
- Computes an ALU result into register C and updates Z/N/V status.
- Writes C back to Rd through the register file's write port, using a start/done handshake to the controller.

Parameters:
- k, 16, datapath width in bits (register file word width).
- n, 3, register-number width (8 registers).

Ports:
- clk  in  1  rising-edge clock, same clock as the register file.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  request to execute one operation; sampled only in IDLE.
- rn  in  n  register number of operand A.
- rm  in  n  register number of operand B.
- rd  in  n  destination register number.
- alu_op  in  2  operation: 00 ADD, 01 SUB, 10 AND, 11 MVN.
- shift  in  2  shift applied to B: 00 none, 01 LSL1, 10 LSR1, 11 ASR1.
- data_in  in  k  register-file read data (combinational from readnum).
- readnum  out  n  register-file read select.
- writenum  out  n  register-file write select.
- write  out  1  register-file write enable.
- wb_data  out  k  write-back data; always equals C.
- status  out  3  {Z,N,V}, registered.
- busy  out  1  high whenever state != IDLE.
- done  out  1  high for exactly the WRITE cycle.

Behaviour:
- Reset (reset_n low at an edge):
  - state <= IDLE; A, B, C, status <= 0; captured fields <= 0.
  - Outputs after reset: readnum=0, writenum=0, write=0, done=0, busy=0, wb_data=0.
- Write gating: write = (state==WRITE) & reset_n, so no write is issued in a cycle where reset is asserted.
- IDLE:
  - readnum=0.
  - If start=1, latch rn/rm/rd/alu_op/shift into rn_q/rm_q/rd_q/op_q/sh_q and go to LOAD_A.
  - Otherwise stay in IDLE.
- LOAD_A: readnum=rn_q; A <= data_in at edge; go to LOAD_B.
- LOAD_B: readnum=rm_q; B <= data_in at edge; go to EXEC.
- EXEC:
  - readnum=0.
  - Bs = shift(B, sh_q):
    - LSL1: {B[k-2:0],0}.
    - LSR1: {0,B[k-1:1]}.
    - ASR1: {B[k-1],B[k-1:1]}.
  - Result:
    - ADD: A+Bs.
    - SUB: A-Bs.
    - AND: A&Bs.
    - MVN: ~Bs.
  - Arithmetic is modulo 2^k; carry-out is discarded.
  - At the edge: C <= result and status <= {Z,N,V}, then go to WRITE.
    - Z = (result==0).
    - N = result[k-1].
    - V = signed overflow for ADD/SUB; V=0 for AND/MVN.
- WRITE: write=1, writenum=rd_q, done=1; go to IDLE.
- writenum = rd_q in all states; only write qualifies it.
- Latency: start sampled at edge t0 gives LOAD_A in cycle 1, LOAD_B in 2, EXEC in 3, WRITE/done in 4, IDLE in 5. Issue rate is one operation per 5 cycles.
- start while busy is ignored; input fields are not re-captured.
- rd_q equal to rn_q or rm_q is legal: operands are already latched, so the write-back is the new value.
- Register file writes land at the end of WRITE. A following operation reads the new value in its LOAD_A cycle, so no forwarding is needed.
- Reset mid-operation: the FSM returns to IDLE at that edge and the interrupted operation is abandoned with no write.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE, LOAD_A, LOAD_B, EXEC, WRITE.
  - alu_op codes.
  - shift codes.
  - Status bit indices: Z=2, N=1, V=0.
- One combinational sub-module, shift_alu (A, B, op, sh -> result, Z, N, V). It is reusable by the later CPU datapath.
- The FSM and the A/B/C/status registers stay in alu_exec_stage.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with start=1 -> busy=0, write=0, done=0, readnum=0, status=000, wb_data=0.
- ADD: bench regfile model with R1=5, R2=3; start with rn=1, rm=2, rd=3, ADD, no shift -> readnum 1 in cycle 1 and 2 in cycle 2; in cycle 4 write=1, writenum=3, wb_data=0x0008, done=1, status=000; afterwards R3=8.
- SUB+LSL: R4=0x0004, R5=0x0002, SUB, LSL1, rd=4 -> wb_data=0x0000, status Z=1 N=0 V=0; R4 becomes 0.
- Overflow: R0=0x7FFF, R1=0x0001, ADD -> wb_data=0x8000, status Z=0 N=1 V=1. Then R0=0x8000, R1=0x0001, SUB -> 0x7FFF, V=1, N=0.
- MVN+ASR: R6=0x8000 as rm, MVN, ASR1 -> Bs=0xC000, wb_data=0x3FFF, status 000. Also MVN with LSR1 on 0x8000 -> 0xBFFF, N=1.
- Busy/reset: pulse start again in cycles 1–4 -> ignored, exactly one write. Separately, drop reset_n in the EXEC cycle -> no write ever asserted, IDLE next cycle, C=0, status=000; a new start afterwards completes normally.
